// File: rtl/wb_arbiter_if.sv
// Signal bundle around the two-master Wishbone arbiter: both master ports, the shared slave bus and the grant monitor.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding masters and slave.
interface wb_arbiter_if;
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m0_we_i;
    logic [31:0] m0_adr_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o;
    logic        m0_err_o;
    logic        m0_rty_o;

    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m1_we_i;
    logic [31:0] m1_adr_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o;
    logic        m1_err_o;
    logic        m1_rty_o;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    logic [1:0]  grant_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master Wishbone B4 classic round-robin arbiter; the grant is held for a whole cyc.
// Define WB_ARBITER_TIMEOUT_EN to add a watchdog that ends stalled strobes with err.
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    wb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        last_next;
    logic [1:0]  grant;
    logic        term;
    logic        timeout;
    logic        sel_cyc;
    logic        sel_stb;

    assign term = bus.ack_i | bus.err_i | bus.rty_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // last == 1 means m1 owned most recently, so m0 wins a simultaneous request
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i)
                    state_next = last ? GRANT0 : GRANT1;
                else if (bus.m0_cyc_i)
                    state_next = GRANT0;
                else if (bus.m1_cyc_i)
                    state_next = GRANT1;
            end
            GRANT0: begin
                if (!bus.m0_cyc_i || timeout) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end
            end
            GRANT1: begin
                if (!bus.m1_cyc_i || timeout) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst_ni so every grant-dependent output drops in the same timestep as reset
    always_comb begin
        grant = 2'b00;
        if (rst_ni) begin
            case (state)
                GRANT0:  grant = 2'b01;
                GRANT1:  grant = 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign bus.grant_o = grant;

    always_comb begin
        sel_cyc    = 1'b0;
        sel_stb    = 1'b0;
        bus.we_o   = 1'b0;
        bus.adr_o  = 32'h0;
        bus.sel_o  = 4'h0;
        bus.dat_o  = 32'h0;
        if (grant[0]) begin
            sel_cyc   = bus.m0_cyc_i;
            sel_stb   = bus.m0_stb_i;
            bus.we_o  = bus.m0_we_i;
            bus.adr_o = bus.m0_adr_i;
            bus.sel_o = bus.m0_sel_i;
            bus.dat_o = bus.m0_dat_i;
        end else if (grant[1]) begin
            sel_cyc   = bus.m1_cyc_i;
            sel_stb   = bus.m1_stb_i;
            bus.we_o  = bus.m1_we_i;
            bus.adr_o = bus.m1_adr_i;
            bus.sel_o = bus.m1_sel_i;
            bus.dat_o = bus.m1_dat_i;
        end
    end

    assign bus.cyc_o = sel_cyc & ~timeout;
    assign bus.stb_o = sel_stb & ~timeout;

    assign bus.m0_dat_o = bus.dat_i;
    assign bus.m1_dat_o = bus.dat_i;
    assign bus.m0_ack_o = bus.ack_i & grant[0];
    assign bus.m1_ack_o = bus.ack_i & grant[1];
    assign bus.m0_err_o = (bus.err_i | timeout) & grant[0];
    assign bus.m1_err_o = (bus.err_i | timeout) & grant[1];
    assign bus.m0_rty_o = bus.rty_i & grant[0];
    assign bus.m1_rty_o = bus.rty_i & grant[1];

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [15:0] wdog_cnt;
    logic        req_active;

    assign req_active = sel_cyc & sel_stb;
    // A real termination in the expiry cycle takes precedence over the watchdog
    assign timeout    = req_active && !term && (wdog_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wdog_cnt <= 16'h0;
        else if (!req_active || term || timeout)
            wdog_cnt <= 16'h0;
        else
            wdog_cnt <= wdog_cnt + 16'h1;
    end
`else
    logic [15:0] timeout_unused;
    logic        term_unused;

    assign timeout        = 1'b0;
    assign timeout_unused = 16'(TIMEOUT_CYCLES);
    assign term_unused    = term;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: expected grants and read data are queued when stimulus is driven.
// Build with WB_ARBITER_TIMEOUT_EN defined to exercise the watchdog path instead of the stall path.
module tb_wb_arbiter;

    logic clk_i;
    logic rst_ni;
    int   compared;
    int   mismatched;
    logic [1:0]  exp_grant[$];
    logic [31:0] exp_data[$];

    wb_arbiter_if bus();

    wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_inputs();
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
        bus.m0_adr_i = 32'h0; bus.m0_sel_i = 4'h0; bus.m0_dat_i = 32'h0;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        bus.m1_adr_i = 32'h0; bus.m1_sel_i = 4'h0; bus.m1_dat_i = 32'h0;
        bus.dat_i = 32'h0; bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
    endtask

    // Steps until some master is granted, giving up after a few cycles
    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            step();
            ok = (bus.grant_o != 2'b00);
        end
    endtask

    initial begin
        logic       ok;
        logic [1:0] g;
        compared   = 0;
        mismatched = 0;
        clear_inputs();
        rst_ni = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant_o), 32'h0);
        check("rst_cyc_o", 32'(bus.cyc_o), 32'h0);
        check("rst_m0_ack", 32'(bus.m0_ack_o), 32'h0);
        step();
        step();
        rst_ni = 1'b1;

        // m0 read with two wait states
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h2000_0000; bus.m0_sel_i = 4'hf;
        #1;
        check("t1_idle_grant", 32'(bus.grant_o), 32'h0);
        check("t1_idle_cyc_o", 32'(bus.cyc_o), 32'h0);
        step();
        check("t1_grant", 32'(bus.grant_o), 32'h1);
        check("t1_cyc_o", 32'(bus.cyc_o), 32'h1);
        check("t1_adr_o", bus.adr_o, 32'h2000_0000);
        check("t1_sel_o", 32'(bus.sel_o), 32'hf);
        exp_data.push_back(32'hCAFE_0123);
        check("t1_wait0_ack", 32'(bus.m0_ack_o), 32'h0);
        step();
        check("t1_wait1_ack", 32'(bus.m0_ack_o), 32'h0);
        step();
        bus.ack_i = 1'b1; bus.dat_i = 32'hCAFE_0123;
        #1;
        check("t1_m0_ack", 32'(bus.m0_ack_o), 32'h1);
        check("t1_m1_ack", 32'(bus.m1_ack_o), 32'h0);
        check("t1_m0_dat", bus.m0_dat_o, exp_data.pop_front());
        step();
        bus.ack_i = 1'b0; bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
        #1;
        check("t1_ack_once", 32'(bus.m0_ack_o), 32'h0);
        check("t1_grant_hold", 32'(bus.grant_o), 32'h1);
        step();
        check("t1_grant_idle", 32'(bus.grant_o), 32'h0);

        // Simultaneous requests alternate owners
        do_reset();
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_grant(ok);
            check($sformatf("t2_wait_%0d", r), 32'(ok), 32'h1);
            g = exp_grant.pop_front();
            check($sformatf("t2_order_%0d", r), 32'(bus.grant_o), 32'(g));
            bus.ack_i = 1'b1;
            #1;
            check($sformatf("t2_acks_%0d", r), 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'(g));
            step();
            bus.ack_i = 1'b0;
            if (g[0]) begin bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; end
            else      begin bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; end
            step();
            check($sformatf("t2_idle_%0d", r), 32'(bus.grant_o), 32'h0);
            if (g[0]) begin bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; end
            else      begin bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; end
        end
        clear_inputs();
        step();

        // m1 keeps cyc across three transfers while m0 waits
        do_reset();
        exp_grant.push_back(2'b10); exp_grant.push_back(2'b01);
        bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'h1000_0040;
        wait_grant(ok);
        check("t3_wait", 32'(ok), 32'h1);
        check("t3_grant_m1", 32'(bus.grant_o), 32'(exp_grant.pop_front()));
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.ack_i = 1'b1; bus.dat_i = 32'h0BAD_0000 + 32'(k);
            exp_data.push_back(32'h0BAD_0000 + 32'(k));
            #1;
            check($sformatf("t3_acks_%0d", k), 32'({bus.m1_ack_o, bus.m0_ack_o}), 32'h2);
            check($sformatf("t3_dat_%0d", k), bus.m1_dat_o, exp_data.pop_front());
            step();
            bus.ack_i = 1'b0;
            #1;
            check($sformatf("t3_hold_%0d", k), 32'(bus.grant_o), 32'h2);
        end
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
        step();
        check("t3_idle", 32'(bus.grant_o), 32'h0);
        step();
        check("t3_grant_m0", 32'(bus.grant_o), 32'(exp_grant.pop_front()));
        clear_inputs();
        step();

        // Slave never answers m0
        do_reset();
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h5000_0000;
        bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
`ifdef WB_ARBITER_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            step();
            check($sformatf("t4_noerr_%0d", c), 32'(bus.m0_err_o), 32'h0);
            check($sformatf("t4_grant_%0d", c), 32'(bus.grant_o), 32'h1);
        end
        step();
        check("t4_m0_err", 32'(bus.m0_err_o), 32'h1);
        check("t4_m1_err", 32'(bus.m1_err_o), 32'h0);
        check("t4_cyc_forced", 32'(bus.cyc_o), 32'h0);
        check("t4_stb_forced", 32'(bus.stb_o), 32'h0);
        step();
        check("t4_idle", 32'(bus.grant_o), 32'h0);
        step();
        check("t4_grant_m1", 32'(bus.grant_o), 32'h2);
`else
        for (int c = 1; c <= 100; c++) begin
            step();
            check($sformatf("t4_noerr_%0d", c), 32'(bus.m0_err_o), 32'h0);
            check($sformatf("t4_grant_%0d", c), 32'(bus.grant_o), 32'h1);
        end
`endif
        clear_inputs();
        step();

        // Reset in the middle of an m1 strobe
        do_reset();
        bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
        wait_grant(ok);
        check("t5_wait", 32'(ok), 32'h1);
        check("t5_grant_m1", 32'(bus.grant_o), 32'h2);
        check("t5_stb_on", 32'(bus.stb_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("t5_rst_cyc", 32'(bus.cyc_o), 32'h0);
        check("t5_rst_stb", 32'(bus.stb_o), 32'h0);
        check("t5_rst_grant", 32'(bus.grant_o), 32'h0);
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
        step();
        rst_ni = 1'b1;
        #1;
        check("t5_rel_idle", 32'(bus.grant_o), 32'h0);
        step();
        check("t5_first_m0", 32'(bus.grant_o), 32'h1);
        clear_inputs();

        check("sb_empty", 32'(exp_grant.size() + exp_data.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
